fetch_stage: RTL and testbench

Instruction fetch stage for the 64-bit RISC-V core. Holds the PC, issues word requests to instruction memory over a req/ack handshake, and presents one registered instruction at a time, with its PC, to the decode stage. `if_opc` drives the opcode input of the main control decoder. Supports decode back-pressure (`stall`) and branch redirect/flush, including redirect while a memory request is still outstanding.

---
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: holds the PC, requests words from imem and presents one instruction to decode.
// Latency: if_valid rises on the edge that samples imem_ack; a redirect costs at least two edges.
// Backpressure: stall freezes the output slot; one extra word lands in a skid slot and requests pause.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_insn,
    output logic [6:0]  if_opc
);

    // REQ: request outstanding. SKID: output full, one word parked. DROP: finish a stale request.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        SKID = 2'd1,
        DROP = 2'd2
    } fetchState_t;

    localparam logic [63:0] ALIGN_MASK = ~64'h3;

    fetchState_t state, stateNext;

    logic [63:0] pc, pcNext;
    logic [63:0] reqAddr, reqAddrNext;
    logic        outValid, outValidNext;
    logic [63:0] outPc, outPcNext;
    logic [31:0] outInsn, outInsnNext;
    logic [63:0] skPc, skPcNext;
    logic [31:0] skInsn, skInsnNext;

    logic        transfer;
    logic        slotFree;
    logic        ackSeen;
    logic [63:0] redirTarget;
    logic [63:0] reqAddrInc;

    // Handshake helpers shared by the next-state logic.
    always_comb begin
        transfer    = outValid && !stall;
        slotFree    = !outValid || transfer;
        ackSeen     = imem_ack && ((state == REQ) || (state == DROP));
        redirTarget = redirect_pc & ALIGN_MASK;
        reqAddrInc  = reqAddr + 64'd4;
    end

    // Next-state and datapath updates; redirect overrides everything else.
    always_comb begin
        stateNext    = state;
        pcNext       = pc;
        reqAddrNext  = reqAddr;
        outValidNext = outValid && !transfer;
        outPcNext    = outPc;
        outInsnNext  = outInsn;
        skPcNext     = skPc;
        skInsnNext   = skInsn;

        unique case (state)
            REQ: begin
                if (redirect) begin
                    pcNext       = redirTarget;
                    outValidNext = 1'b0;
                    if (ackSeen) begin
                        // Returned word belongs to the old path; reissue at the target.
                        reqAddrNext = redirTarget;
                        stateNext   = REQ;
                    end else begin
                        // Memory still owes us a word; wait it out before retargeting.
                        stateNext = DROP;
                    end
                end else if (ackSeen) begin
                    pcNext = reqAddrInc;
                    if (slotFree) begin
                        outValidNext = 1'b1;
                        outPcNext    = reqAddr;
                        outInsnNext  = imem_rdata;
                        reqAddrNext  = reqAddrInc;
                    end else begin
                        skPcNext   = reqAddr;
                        skInsnNext = imem_rdata;
                        stateNext  = SKID;
                    end
                end
            end
            SKID: begin
                if (redirect) begin
                    // Parked word is on the old path and is simply forgotten.
                    pcNext       = redirTarget;
                    reqAddrNext  = redirTarget;
                    outValidNext = 1'b0;
                    stateNext    = REQ;
                end else if (slotFree) begin
                    outValidNext = 1'b1;
                    outPcNext    = skPc;
                    outInsnNext  = skInsn;
                    reqAddrNext  = pc;
                    stateNext    = REQ;
                end
            end
            DROP: begin
                if (redirect) begin
                    // Later redirect replaces the earlier target; request stays pending.
                    pcNext       = redirTarget;
                    outValidNext = 1'b0;
                end else if (ackSeen) begin
                    reqAddrNext = pc;
                    stateNext   = REQ;
                end
            end
            default: begin
                stateNext = REQ;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= REQ;
            pc       <= RESET_PC & ALIGN_MASK;
            reqAddr  <= RESET_PC & ALIGN_MASK;
            outValid <= 1'b0;
            outPc    <= 64'h0;
            outInsn  <= NOP_INSN;
            skPc     <= 64'h0;
            skInsn   <= 32'h0;
        end else begin
            state    <= stateNext;
            pc       <= pcNext;
            reqAddr  <= reqAddrNext;
            outValid <= outValidNext;
            outPc    <= outPcNext;
            outInsn  <= outInsnNext;
            skPc     <= skPcNext;
            skInsn   <= skInsnNext;
        end
    end

    // Outputs: NOP substituted whenever nothing valid is held.
    always_comb begin
        imem_req  = (state == REQ) || (state == DROP);
        imem_addr = reqAddr;
        if_valid  = outValid;
        if_pc     = outPc;
        if_insn   = outValid ? outInsn : NOP_INSN;
        if_opc    = if_insn[6:0];
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        ackEn;

    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_insn;
    logic [6:0]  if_opc;

    logic        reqW;
    logic [63:0] addrW;
    logic        ackW;
    logic [31:0] rdataW;
    logic        validW;
    logic [63:0] pcW;
    logic [31:0] insnW;
    logic [6:0]  opcW;

    int checks = 0;
    int errors = 0;

    // Memory models: word equals its own address, ack gated by request.
    assign imem_ack   = ackEn && imem_req;
    assign imem_rdata = imem_addr[31:0];
    assign ackW       = reqW;
    assign rdataW     = addrW[31:0];

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_insn(if_insn), .if_opc(if_opc)
    );

    fetch_stage #(.RESET_PC(WRAP_PC)) dutW (
        .clk(clk), .rst_n(rst_n),
        .imem_req(reqW), .imem_addr(addrW), .imem_ack(ackW), .imem_rdata(rdataW),
        .redirect(1'b0), .redirect_pc(64'h0), .stall(1'b0),
        .if_valid(validW), .if_pc(pcW), .if_insn(insnW), .if_opc(opcW)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        stl;
        logic        rdr;
        logic [63:0] rpc;
        logic        ack;
        logic        eValid;
        logic [63:0] ePc;
        logic [31:0] eInsn;
        logic        eReq;
        logic [63:0] eAddr;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic stl, input logic rdr, input logic [63:0] rpc, input logic ack,
                       input logic eValid, input logic [63:0] ePc, input logic [31:0] eInsn,
                       input logic eReq, input logic [63:0] eAddr);
        vec_t v;
        v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.ack = ack;
        v.eValid = eValid; v.ePc = ePc; v.eInsn = eInsn; v.eReq = eReq; v.eAddr = eAddr;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chkMain(input string tag, input logic eValid, input logic [63:0] ePc,
                           input logic [31:0] eInsn, input logic eReq, input logic [63:0] eAddr);
        logic [31:0] insnCopy;
        insnCopy = eInsn;
        chk({tag, "_valid"}, {63'h0, if_valid}, {63'h0, eValid});
        chk({tag, "_pc"}, if_pc, ePc);
        chk({tag, "_insn"}, {32'h0, if_insn}, {32'h0, eInsn});
        chk({tag, "_opc"}, {57'h0, if_opc}, {57'h0, insnCopy[6:0]});
        chk({tag, "_req"}, {63'h0, imem_req}, {63'h0, eReq});
        chk({tag, "_addr"}, imem_addr, eAddr);
    endtask

    task automatic chkWrap(input string tag, input logic eValid, input logic [63:0] ePc,
                           input logic [31:0] eInsn, input logic [63:0] eAddr);
        logic [31:0] insnCopy;
        insnCopy = eInsn;
        chk({tag, "_valid"}, {63'h0, validW}, {63'h0, eValid});
        chk({tag, "_pc"}, pcW, ePc);
        chk({tag, "_insn"}, {32'h0, insnW}, {32'h0, eInsn});
        chk({tag, "_opc"}, {57'h0, opcW}, {57'h0, insnCopy[6:0]});
        chk({tag, "_addr"}, addrW, eAddr);
    endtask

    initial begin
        // stall redirect rpc ack | valid pc insn req addr   (expected after the edge)
        add(0, 0, 64'h0, 1,    1, 64'h0,    32'h0,    1, 64'h4);
        add(0, 0, 64'h0, 1,    1, 64'h4,    32'h4,    1, 64'h8);
        add(0, 0, 64'h0, 1,    1, 64'h8,    32'h8,    1, 64'hC);
        for (int k = 0; k < 4; k++)
            add(1, 0, 64'h0, 1, 1, 64'h8,   32'h8,    0, 64'hC);
        add(0, 0, 64'h0, 1,    1, 64'hC,    32'hC,    1, 64'h10);
        add(0, 0, 64'h0, 1,    1, 64'h10,   32'h10,   1, 64'h14);
        add(0, 0, 64'h0, 0,    0, 64'h10,   NOP,      1, 64'h14);
        add(0, 0, 64'h0, 0,    0, 64'h10,   NOP,      1, 64'h14);
        add(0, 0, 64'h0, 1,    1, 64'h14,   32'h14,   1, 64'h18);
        add(0, 0, 64'h0, 0,    0, 64'h14,   NOP,      1, 64'h18);
        add(0, 0, 64'h0, 0,    0, 64'h14,   NOP,      1, 64'h18);
        add(0, 0, 64'h0, 1,    1, 64'h18,   32'h18,   1, 64'h1C);
        add(0, 0, 64'h0, 1,    1, 64'h1C,   32'h1C,   1, 64'h20);
        add(0, 1, 64'h1002, 0, 0, 64'h1C,   NOP,      1, 64'h20);
        add(0, 0, 64'h0, 0,    0, 64'h1C,   NOP,      1, 64'h20);
        add(0, 0, 64'h0, 1,    0, 64'h1C,   NOP,      1, 64'h1000);
        add(0, 0, 64'h0, 1,    1, 64'h1000, 32'h1000, 1, 64'h1004);
        add(1, 1, 64'h2000, 1, 0, 64'h1000, NOP,      1, 64'h2000);
        add(0, 0, 64'h0, 1,    1, 64'h2000, 32'h2000, 1, 64'h2004);
        add(0, 1, 64'h40, 0,   0, 64'h2000, NOP,      1, 64'h2004);
        add(0, 1, 64'h80, 0,   0, 64'h2000, NOP,      1, 64'h2004);
        add(0, 0, 64'h0, 1,    0, 64'h2000, NOP,      1, 64'h80);
        add(0, 0, 64'h0, 1,    1, 64'h80,   32'h80,   1, 64'h84);
        add(1, 0, 64'h0, 1,    1, 64'h80,   32'h80,   0, 64'h84);
        add(1, 1, 64'h303, 0,  0, 64'h80,   NOP,      1, 64'h300);
        add(0, 0, 64'h0, 1,    1, 64'h300,  32'h300,  1, 64'h304);

        stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0; ackEn = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chkMain("reset", 1'b0, 64'h0, NOP, 1'b1, 64'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < tv.size(); i++) begin
            stall       = tv[i].stl;
            redirect    = tv[i].rdr;
            redirect_pc = tv[i].rpc;
            ackEn       = tv[i].ack;
            @(posedge clk);
            #1;
            chkMain($sformatf("v%0d", i), tv[i].eValid, tv[i].ePc, tv[i].eInsn, tv[i].eReq, tv[i].eAddr);
            @(negedge clk);
        end

        // Wrap-around instance: fresh reset, then zero-wait fetch across 2^64.
        stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0; ackEn = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chkWrap("wrap_reset", 1'b0, 64'h0, NOP, WRAP_PC);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chkWrap("wrap0", 1'b1, WRAP_PC, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC);
        @(posedge clk); #1;
        chkWrap("wrap1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 64'h0);
        @(posedge clk); #1;
        chkWrap("wrap2", 1'b1, 64'h0, 32'h0, 64'h4);

        // Reset between clock edges must take effect without a clock.
        #2 rst_n = 1'b0;
        #1;
        chkWrap("async_rst_wrap", 1'b0, 64'h0, NOP, WRAP_PC);
        chk("async_rst_wrap_req", {63'h0, reqW}, 64'h1);
        chkMain("async_rst_main", 1'b0, 64'h0, NOP, 1'b1, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
